// File: rtl/sync_fifo_pkg.sv
// Shared width defaults for the byte FIFO and its neighbours in the datapath,
// so producer, FIFO and consumer instances agree on word and address widths.
package sync_fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_ADDR_WIDTH = 4;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo: push/pop strobes, head word and status.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) ();

  logic [DATA_WIDTH-1:0] w_data;
  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;

  modport master (
    output w_data, wr, rd,
    input  r_data, empty, full, count
  );

  modport slave (
    input  w_data, wr, rd,
    output r_data, empty, full, count
  );

endinterface

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag bookkeeping for sync_fifo; decides which
// strobes are accepted each edge. Storage lives in the top level.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  push_o,
  output logic [ADDR_WIDTH-1:0] wptr_o,
  output logic [ADDR_WIDTH-1:0] rptr_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o
);

  localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  pop;

  // Flags decode registered occupancy only, so rd/wr never reach them combinationally.
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH);
  assign wptr_o  = wptr_q;
  assign rptr_o  = rptr_q;
  assign count_o = count_q;

  always_comb begin
    push_o  = wr && (!full_o || rd) && !reset;
    pop     = rd && !empty_o;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_o) wptr_d = wptr_q + PTR_ONE;
    if (pop)    rptr_d = rptr_q + PTR_ONE;
    case ({push_o, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO: register array plus head-word mux;
// bookkeeping is delegated to sync_fifo_ctrl.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input logic       clk,
  input logic       reset,
  sync_fifo_if.slave bus
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic                  empty;
  logic                  full;
  logic [ADDR_WIDTH:0]   count;

  sync_fifo_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk    (clk),
    .reset  (reset),
    .wr     (bus.wr),
    .rd     (bus.rd),
    .push_o (push),
    .wptr_o (wptr),
    .rptr_o (rptr),
    .empty_o(empty),
    .full_o (full),
    .count_o(count)
  );

  // Array is deliberately left out of reset; stale words are masked by empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr] <= bus.w_data;
  end

  assign bus.r_data = empty ? '0 : mem_q[rptr];
  assign bus.empty  = empty;
  assign bus.full   = full;
  assign bus.count  = count;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: stimulus pushes accepted words into a
// reference queue, a negedge monitor pops and checks head data and status.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;
  logic [7:0] ref_q [$];

  sync_fifo_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: status against the reference occupancy, head word on every pop.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("mon_count", int'(bus.count), ref_q.size());
      chk("mon_empty", int'(bus.empty), int'(ref_q.size() == 0));
      chk("mon_full",  int'(bus.full),  int'(ref_q.size() == 16));
      if (ref_q.size() == 0) begin
        chk("mon_rdata_empty", int'(bus.r_data), 0);
      end else if (bus.rd) begin
        chk("mon_pop_data", int'(bus.r_data), int'(ref_q[0]));
        void'(ref_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at the following posedge+1 with strobes low.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bit acc;
    bus.wr     = w;
    bus.rd     = r;
    bus.w_data = d;
    acc = w && ((ref_q.size() < 16) || r);
    @(posedge clk);
    if (acc) ref_q.push_back(d);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    ref_q.delete();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.wr     = 1'b0;
    bus.rd     = 1'b0;
    bus.w_data = 8'h00;
    @(posedge clk);
    #1;
    do_reset();
    mon_en = 1'b1;
    chk("rst_count", int'(bus.count), 0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full",  int'(bus.full),  0);
    chk("rst_rdata", int'(bus.r_data), 0);

    step(1'b1, 1'b0, 8'd3);
    step(1'b1, 1'b0, 8'd5);
    chk("w2_rdata", int'(bus.r_data), 3);
    chk("w2_empty", int'(bus.empty), 0);
    chk("w2_count", int'(bus.count), 2);
    step(1'b0, 1'b1, 8'h00);
    chk("r1_rdata", int'(bus.r_data), 5);
    chk("r1_count", int'(bus.count), 1);
    step(1'b0, 1'b1, 8'h00);
    chk("r2_empty", int'(bus.empty), 1);
    chk("r2_rdata", int'(bus.r_data), 0);
    chk("r2_count", int'(bus.count), 0);

    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);
    chk("underrun_count", int'(bus.count), 0);
    chk("underrun_empty", int'(bus.empty), 1);
    step(1'b1, 1'b0, 8'h7A);
    chk("after_underrun_rdata", int'(bus.r_data), 8'h7A);
    step(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i));
    chk("fill_full",  int'(bus.full),  1);
    chk("fill_count", int'(bus.count), 16);
    step(1'b1, 1'b0, 8'hFF);
    chk("overrun_count", int'(bus.count), 16);
    chk("overrun_head",  int'(bus.r_data), 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("drain_empty", int'(bus.empty), 1);

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("wrap_head",  int'(bus.r_data), 8'h20);
    chk("wrap_count", int'(bus.count), 12);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00);
    chk("wrap_empty", int'(bus.empty), 1);

    step(1'b1, 1'b0, 8'h30);
    step(1'b1, 1'b0, 8'h31);
    step(1'b1, 1'b0, 8'h32);
    step(1'b1, 1'b1, 8'h33);
    chk("rw_mid_count", int'(bus.count), 3);
    chk("rw_mid_head",  int'(bus.r_data), 8'h31);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h11);
    chk("rw_empty_count", int'(bus.count), 1);
    chk("rw_empty_rdata", int'(bus.r_data), 8'h11);
    step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    step(1'b1, 1'b1, 8'h55);
    chk("rw_full_count", int'(bus.count), 16);
    chk("rw_full_head",  int'(bus.r_data), 8'h41);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00);
    chk("rw_full_tail", int'(bus.r_data), 8'h55);
    step(1'b0, 1'b1, 8'h00);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i));
    chk("pre_rst_count", int'(bus.count), 5);
    do_reset();
    chk("mid_rst_count", int'(bus.count), 0);
    chk("mid_rst_empty", int'(bus.empty), 1);
    chk("mid_rst_full",  int'(bus.full),  0);
    chk("mid_rst_rdata", int'(bus.r_data), 0);
    step(1'b1, 1'b0, 8'h42);
    chk("post_rst_rdata", int'(bus.r_data), 8'h42);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock byte FIFO buffering data between a producer (e.g. UART receiver) and a consumer (e.g. command/ALU interface) in the tp_final datapath.
- Circular buffer with independent write and read strobes.
- First-word-fall-through: the head word is always visible on r_data; rd pops it.
- Status flags (empty, full) and an occupancy count let the consumer poll before reading.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH = 16 words.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- w_data  input  DATA_WIDTH  word to push.
- wr  input  1  write strobe; one push per rising edge while high.
- rd  input  1  read strobe; one pop per rising edge while high.
- r_data  output  DATA_WIDTH  head-of-queue word (combinational from storage).
- empty  output  1  high when the FIFO holds 0 words.
- full  output  1  high when the FIFO holds 2**ADDR_WIDTH words.
- count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset; it is sampled only at the clk rising edge.
- Strobes are level-sampled at each rising edge. A pulse shorter than one period that covers one edge gives exactly one operation. Callers assert a strobe for one cycle per operation.
- Reset (synchronous, priority over rd/wr):
  - write pointer = 0, read pointer = 0, count = 0
  - empty = 1, full = 0, r_data = 0
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored data at that edge.
- Storage: 2**ADDR_WIDTH x DATA_WIDTH register array, written only on an accepted push.
- Push accepted when wr=1 and (full=0 or rd=1):
  - mem[wptr] <= w_data
  - wptr <= wptr+1, wrapping modulo depth
- Pop accepted when rd=1 and empty=0:
  - rptr <= rptr+1, wrapping modulo depth
- Ignored operations: wr while full with rd=0, and rd while empty. Neither changes state; no error flag.
- Simultaneous rd & wr:
  - Not empty and not full: push and pop both occur; count unchanged.
  - Empty: push only; count goes to 1.
  - Full: pop and push both occur; count stays at depth.
- count: +1 on push only, -1 on pop only, unchanged otherwise.
- Flags are derived from the registered state, equivalent to empty = (count==0) and full = (count==depth). Both update in the cycle after the causing edge. No combinational path from rd/wr.
- r_data = mem[rptr] when empty=0, and 0 when empty=1.
  - Written data becomes visible one edge after its push into an empty FIFO.
  - After a pop, the next word is visible immediately after that edge.
- Latency: write-to-r_data 1 cycle (empty FIFO); read-to-next-word 1 cycle.
- Pointer wrap: ADDR_WIDTH-bit pointers roll over from depth-1 to 0 with no discontinuity in data order.

Decomposition:
- Shared package: DATA_WIDTH and ADDR_WIDTH defaults, so UART and FIFO instances agree on widths.
- One natural sub-module, fifo_ctrl: pointers, count, flags, and accept logic.
- The top level holds the register array and the r_data mux.

Test Plan:
- Reset, then write 3, then write 5 (one-cycle wr each) -> r_data=3, empty=0, count=2; rd -> r_data=5, count=1; rd -> empty=1, r_data=0, count=0.
- Five further rd pulses on empty FIFO -> count stays 0, empty stays 1, pointers unchanged; next write of 0x7A appears on r_data.
- Write 0x00..0x0F (16 words) -> full=1, count=16; write 0xFF -> ignored; 16 reads return 0x00..0x0F in order, then empty=1.
- Write 10, read 10, write 12 words 0x20..0x2B, read all -> pointers wrap past 15, order 0x20..0x2B preserved.
- Simultaneous rd&wr:
  - count=3 -> count stays 3, head advances.
  - Empty with w_data=0x11 -> count=1, r_data=0x11.
  - Full -> count stays 16, newest word appended.
- Assert reset with count=5 -> next cycle count=0, empty=1, full=0, r_data=0; subsequent write 0x42 reads back 0x42.
